out_port_uart: RTL

//  Output peripheral downstream of the SAP-2 core. Watches the core's A_OUT accumulator

---
 rtl/out_port_uart.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/out_port_uart.sv
// out_port_uart
//   Output peripheral beside the SAP-2 core. Every change of the core's
//   accumulator output (A_IN) is queued in a small FIFO. Queued bytes are
//   sent as 8N1 UART frames on TX: start bit, 8 data bits LSB first, stop bit.
//
// Parameters
//   CLKS_PER_BIT  CLK cycles per UART bit (>=2)
//   FIFO_DEPTH    FIFO entries (power of two, >=2)
//
// Ports
//   CLK       in   system clock, rising edge
//   RST_N     in   asynchronous active-low reset
//   EN        in   1 = queue changes of A_IN; 0 = track A_IN without queuing
//   A_IN      in   accumulator value from the core
//   TX        out  UART serial output, idle high, driven from a flop
//   BUSY      out  FIFO non-empty or a frame in flight
//   FULL      out  FIFO full
//   OVERFLOW  out  sticky: a change was dropped because the FIFO was full
//   LEVEL     out  FIFO occupancy, 0..FIFO_DEPTH
module out_port_uart #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic                          CLK,
   input  logic                          RST_N,
   input  logic                          EN,
   input  logic [7:0]                    A_IN,
   output logic                          TX,
   output logic                          BUSY,
   output logic                          FULL,
   output logic                          OVERFLOW,
   output logic [$clog2(FIFO_DEPTH):0]   LEVEL
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t             state;
   logic [7:0]         prev_a;
   logic [7:0]         mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [LVL_W-1:0]   level;
   logic [CNT_W-1:0]   baud_cnt;
   logic [2:0]         bit_cnt;
   logic [7:0]         shift;
   logic               tx_q;
   logic               push;
   logic               pop;
   logic               wr_en;
   logic               full;
   logic               baud_end;

   assign full     = (level == LVL_W'(FIFO_DEPTH));
   assign baud_end = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign push     = EN && (A_IN != prev_a);
   // A push into a full FIFO still succeeds when the FSM frees a slot at the same edge.
   assign wr_en    = push && (!full || pop);

   // Pops look at the registered level only, so a value written at edge k
   // cannot leave the FIFO before edge k+1.
   always_comb begin
      pop = 1'b0;
      if (level != '0) begin
         case (state)
            IDLE:    pop = 1'b1;
            STOP:    pop = baud_end;
            default: pop = 1'b0;
         endcase
      end
   end

   // FIFO storage carries no reset; contents are meaningless once pointers clear.
   always_ff @(posedge CLK) begin
      if (wr_en) mem[wr_ptr] <= A_IN;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         prev_a   <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         OVERFLOW <= 1'b0;
      end else begin
         prev_a <= A_IN;
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (push && full && !pop) OVERFLOW <= 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state    <= IDLE;
         tx_q     <= 1'b1;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shift    <= '0;
      end else begin
         case (state)
            IDLE: begin
               tx_q <= 1'b1;
               if (pop) begin
                  shift    <= mem[rd_ptr];
                  tx_q     <= 1'b0;
                  baud_cnt <= '0;
                  state    <= START;
               end
            end
            START: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  tx_q     <= shift[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  shift    <= shift >> 1;
                  if (bit_cnt == 3'd7) begin
                     tx_q  <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     // shift[1] is the bit that lands in shift[0] at this edge.
                     tx_q    <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (pop) begin
                     shift <= mem[rd_ptr];
                     tx_q  <= 1'b0;
                     state <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign TX    = tx_q;
   assign FULL  = full;
   assign LEVEL = level;
   // Derived only from flops; TX itself never passes through this logic.
   assign BUSY  = (level != '0) || (state != IDLE);

endmodule
